alu_issue: RTL and testbench
============================

# alu_issue

Issue and writeback stage for the 4-bit `alu`. It accepts instructions over a valid/ready handshake and reads two operands from a 4-entry × 4-bit register file. It drives the ALU's `a`, `b` and `opcode` inputs with a NOP-bracketed opcode sequence, so that every operation creates an opcode transition. It then captures `out` and `carryout` and writes the result back to the destination register.

## Interface
Parameters:
- `NOP_OP`, 4'b1111: idle opcode driven to the ALU; the ALU produces 0 for it.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `instr_valid`, in, 1: instruction present.
- `instr_ready`, out, 1: stage can accept an instruction.
- `instr_opcode`, in, 4: ALU opcode.
- `instr_rd`, in, 2: destination register.
- `instr_ra`, in, 2: source register A.
- `instr_rb`, in, 2: source register B.
- `host_wr_en`, in, 1: host register-file write.
- `host_wr_addr`, in, 2: host write address.
- `host_wr_data`, in, 4: host write data.
- `alu_a`, out, 4: to ALU `a`.
- `alu_b`, out, 4: to ALU `b`.
- `alu_opcode`, out, 4: to ALU `opcode`.
- `alu_out`, in, 4: from ALU `out`.
- `alu_carryout`, in, 1: from ALU `carryout`.
- `result_valid`, out, 1: one-cycle pulse per completed instruction.
- `result_data`, out, 4: value written back.
- `result_carry`, out, 1: current carry flag.
- `result_err`, out, 1: divide-by-zero flag for this result.
- `busy`, out, 1: high in SETUP and EXEC.

## Operation
- **States:** IDLE, SETUP, EXEC, DONE.
- **Ready:** `instr_ready` = (state == IDLE || state == DONE).
- **Accept:** `instr_valid && instr_ready` at an edge.
  - Latches `rf[ra]` and `rf[rb]` into the operand registers. The register file is read before any same-edge write, so operands are old values.
  - Latches `opcode` and `rd`.
  - Goes to SETUP.
- **SETUP:**
  - `alu_a`/`alu_b` = latched operands; `alu_opcode` = `NOP_OP`.
  - Next state EXEC, unconditionally.
- **EXEC:**
  - `alu_opcode` = latched opcode; operands held.
  - At the edge leaving EXEC the stage captures `alu_out` into `result_data` and writes `rf[rd]`. If the opcode is 0111 it also loads `carry_flag` ← `alu_carryout`.
  - Next state DONE.
- **DONE:**
  - `result_valid` = 1 for exactly one cycle; `alu_opcode` = `NOP_OP`.
  - Next state SETUP if a new instruction is accepted, else IDLE.
- **IDLE:** `alu_opcode` = `NOP_OP`; `alu_a`/`alu_b` hold their last values.
- **Carry:**
  - `carry_flag` changes only on opcode 0111.
  - Every other opcode leaves it unchanged, including subtract, multiply and shift.
  - `result_carry` = `carry_flag`.
- **Divide by zero:** when opcode is 1010 and operand B is 0:
  - `result_data` = 4'h0 and `rf[rd]` ← 4'h0.
  - `result_err` = 1, held until the next capture.
  - `alu_out` is ignored.
  - In every other capture, `result_err` = 0.
- **Width:** results are 4-bit truncated: sub wraps mod 16, multiply keeps the low 4 bits, shifts use the full 4-bit B.
- **Unused opcodes:** 1101–1110 pass through to the ALU and write back 0.
- **Host writes:** applied at any edge in any state.
  - If a host write and the EXEC writeback hit the same address at the same edge, the writeback wins and the host write is dropped.
  - If the addresses differ, both writes occur.

## Timing
- **Reset values:**
  - State IDLE; `rf` all 0; `carry_flag` 0.
  - `alu_a`, `alu_b`, `result_data` = 0; `result_valid` = 0; `result_err` = 0.
  - `alu_opcode` = `NOP_OP`; `instr_ready` = 1; `busy` = 0.
- **Latency:** accept at edge E0.
  - SETUP after E0, EXEC after E1.
  - Writeback and capture at E2; `result_valid` high between E2 and E3.
- **Throughput:** one instruction per 3 cycles with back-to-back valid, because DONE overlaps the next accept.
- **Dependencies:** none. A dependent instruction accepted in DONE reads the already-written value, since the writeback happened at E2.
- **Reset mid-operation:**
  - Asserting `rst` in SETUP or EXEC aborts the operation immediately: no writeback, no `result_valid`.
  - All outputs take their reset values asynchronously.
- **Stable opcode:** `alu_opcode` changes only on clock edges, and each executed opcode is preceded by `NOP_OP`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` mid-cycle.
  - Expect: `alu_opcode` = 4'hF, `instr_ready` = 1, `result_valid` = 0, all `rf` = 0, before the next edge.
- **Add with carry:**
  - Stimulus: host writes `rf0` = 9 and `rf1` = 8, then issues opcode 0111 with rd = 2, ra = 0, rb = 1.
  - Expect: `result_data` = 4'h1, `result_carry` = 1, `rf2` = 1, `result_valid` 3 cycles after accept.
- **Repeated opcode with new operands:**
  - Stimulus: issue two 0000 (AND) instructions back-to-back, 4'hF&4'h3 then 4'hC&4'hA.
  - Expect: results 4'h3 then 4'h8, accepts 3 cycles apart, NOP seen between.
- **Subtract wrap and divide by zero:**
  - Stimulus: 3−5, then 7/0.
  - Expect: 4'hE with the carry flag unchanged from the previous value; then 4'h0 with `result_err` = 1.
- **Write collision:**
  - Stimulus: host write to rd at the same edge as writeback.
  - Expect: `rf[rd]` = ALU result.
  - Stimulus: host write to a different address at that edge.
  - Expect: both writes land.
- **Reset during EXEC:**
  - Stimulus: assert `rst` in EXEC of opcode 0001 into rd = 3.
  - Expect: `rf3` stays 0, no `result_valid` pulse, state IDLE.

Source files
------------

// File: rtl/alu_issue.sv
// Issue and writeback stage for the 4-bit ALU: reads operands from a 4x4 register file,
// drives a NOP-bracketed opcode sequence, and writes the captured result back.
module alu_issue #(
    parameter logic [3:0] NOP_OP = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_opcode,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_ra,
    input  logic [1:0] instr_rb,
    input  logic       host_wr_en,
    input  logic [1:0] host_wr_addr,
    input  logic [3:0] host_wr_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [3:0] alu_out,
    input  logic       alu_carryout,
    output logic       result_valid,
    output logic [3:0] result_data,
    output logic       result_carry,
    output logic       result_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1010;

    state_t     state, state_nxt;
    logic [3:0] rf [4];
    logic [3:0] op_code;
    logic [1:0] op_rd;
    logic       carry_flag;
    logic       accept;
    logic       wb_en;
    logic       wb_err;
    logic [3:0] wb_data;

    assign accept       = instr_valid && instr_ready;
    assign wb_en        = (state == EXEC);
    assign result_valid = (state == DONE);
    assign result_carry = carry_flag;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        busy        = 1'b0;
        alu_opcode  = NOP_OP;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                busy      = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                alu_opcode = op_code;
                state_nxt  = DONE;
            end
            DONE: begin
                instr_ready = 1'b1;
                state_nxt   = accept ? SETUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divide by zero and the unused opcodes ignore whatever the ALU returns.
    always_comb begin
        wb_err  = (op_code == OP_DIV) && (alu_b == 4'd0);
        wb_data = alu_out;
        if (wb_err || op_code == 4'b1101 || op_code == 4'b1110) wb_data = 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= 4'd0;
            alu_b   <= 4'd0;
            op_code <= NOP_OP;
            op_rd   <= 2'd0;
        end else if (accept) begin
            alu_a   <= rf[instr_ra];
            alu_b   <= rf[instr_rb];
            op_code <= instr_opcode;
            op_rd   <= instr_rd;
        end
    end

    // NOTE: the register file is small and must read as zero after reset, so it is reset like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wb_en && op_rd == i[1:0])
                    rf[i] <= wb_data;
                else if (host_wr_en && host_wr_addr == i[1:0])
                    rf[i] <= host_wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_data <= 4'd0;
            result_err  <= 1'b0;
            carry_flag  <= 1'b0;
        end else if (wb_en) begin
            result_data <= wb_data;
            result_err  <= wb_err;
            if (op_code == OP_ADD) carry_flag <= alu_carryout;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a behavioural ALU drives the DUT's ALU inputs,
// and a register-file/flag model predicts every writeback.
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_opcode;
    logic [1:0] instr_rd, instr_ra, instr_rb;
    logic       host_wr_en;
    logic [1:0] host_wr_addr;
    logic [3:0] host_wr_data;
    logic [3:0] alu_a, alu_b, alu_opcode, alu_out;
    logic       alu_carryout;
    logic       result_valid, result_carry, result_err, busy;
    logic [3:0] result_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int mrf [4];
    int mcarry = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd),
        .instr_ra(instr_ra), .instr_rb(instr_rb),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_carryout(alu_carryout),
        .result_valid(result_valid), .result_data(result_data),
        .result_carry(result_carry), .result_err(result_err), .busy(busy)
    );

    // Behavioural ALU: {carryout, out}; divide by zero and opcodes 1101/1110 return junk on purpose.
    function automatic logic [4:0] alu_model(input int op, input int a, input int b);
        int r, c;
        r = 0;
        c = 0;
        case (op)
            0:  r = a & b;
            1:  r = a | b;
            2:  r = a ^ b;
            3:  r = ~a;
            4:  begin r = a - b; c = (a < b) ? 1 : 0; end
            5:  begin r = a * b; c = (r > 15) ? 1 : 0; end
            6:  begin r = a << b; c = (r > 15) ? 1 : 0; end
            7:  begin r = a + b; c = (r > 15) ? 1 : 0; end
            8:  r = a >> b;
            9:  begin r = a + 1; c = (r > 15) ? 1 : 0; end
            10: if (b != 0) r = a / b; else begin r = 15; c = 1; end
            11: r = (b != 0) ? a % b : 0;
            12: r = a - 1;
            13: begin r = a + b + 3; c = 1; end
            14: r = 9;
            default: r = 0;
        endcase
        r = r & 15;
        return {c[0], r[3:0]};
    endfunction

    assign {alu_carryout, alu_out} = alu_model(int'(alu_opcode), int'(alu_a), int'(alu_b));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] addr, input logic [3:0] data);
        host_wr_en   = 1'b1;
        host_wr_addr = addr;
        host_wr_data = data;
        tick();
        host_wr_en = 1'b0;
        mrf[addr] = int'(data);
    endtask

    // hw_phase: 0 no host write, 1 host write at the accept edge, 2 host write at the writeback edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input int hw_phase,
                         input logic [1:0] hw_addr, input logic [3:0] hw_data);
        int a, b, cnt, exp_data;
        logic [4:0] r;
        logic exp_err;
        cnt = 0;
        while (!instr_ready && cnt < 10) begin
            tick();
            cnt++;
        end
        check("ready_before_accept", instr_ready, 1);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_rd     = rd;
        instr_ra     = ra;
        instr_rb     = rb;
        a = mrf[ra];
        b = mrf[rb];
        if (hw_phase == 1) begin
            host_wr_en   = 1'b1;
            host_wr_addr = hw_addr;
            host_wr_data = hw_data;
            mrf[hw_addr] = int'(hw_data);
        end
        tick();
        accept_cyc  = cyc;
        instr_valid = 1'b0;
        host_wr_en  = 1'b0;
        check("setup_opcode_nop", alu_opcode, 4'hF);
        check("setup_alu_a", alu_a, a);
        check("setup_busy", busy, 1);
        check("setup_no_valid", result_valid, 0);
        if (hw_phase == 2) begin
            host_wr_en   = 1'b1;
            host_wr_addr = hw_addr;
            host_wr_data = hw_data;
        end
        tick();
        check("exec_opcode", alu_opcode, op);
        check("exec_alu_b", alu_b, b);
        tick();
        host_wr_en = 1'b0;
        r = alu_model(int'(op), a, b);
        exp_err  = (op == 4'b1010) && (b == 0);
        exp_data = (exp_err || op == 4'b1101 || op == 4'b1110) ? 0 : int'(r[3:0]);
        if (op == 4'b0111) mcarry = int'(r[4]);
        if (hw_phase == 2) mrf[hw_addr] = int'(hw_data);
        mrf[rd] = exp_data;
        check("done_valid", result_valid, 1);
        check("done_data", result_data, exp_data);
        check("done_err", result_err, exp_err);
        check("done_carry", result_carry, mcarry);
        check("done_opcode_nop", alu_opcode, 4'hF);
        check("done_rf_rd", dut.rf[rd], mrf[rd]);
        if (hw_phase != 0) check("done_rf_host", dut.rf[hw_addr], mrf[hw_addr]);
    endtask

    initial begin
        int prev_accept;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_opcode = 4'd0;
        instr_rd = 2'd0;
        instr_ra = 2'd0;
        instr_rb = 2'd0;
        host_wr_en = 1'b0;
        host_wr_addr = 2'd0;
        host_wr_data = 4'd0;
        for (int i = 0; i < 4; i++) mrf[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Mid-cycle reset: outputs must settle before the next edge.
        host_write(2'd1, 4'h6);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) mrf[i] = 0;
        check("rst_opcode", alu_opcode, 4'hF);
        check("rst_ready", instr_ready, 1);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", result_data, 0);
        check("rst_err", result_err, 0);
        check("rst_carry", result_carry, 0);
        check("rst_alu_a", alu_a, 0);
        for (int i = 0; i < 4; i++) check("rst_rf", dut.rf[i], 0);
        tick();
        rst = 1'b0;
        tick();

        // 9 + 8 wraps to 1 with carry.
        host_write(2'd0, 4'd9);
        host_write(2'd1, 4'd8);
        issue(4'b0111, 2'd2, 2'd0, 2'd1, 0, 2'd0, 4'd0);
        check("add_data_const", result_data, 4'h1);
        check("add_carry_const", result_carry, 1);

        // Back-to-back ANDs: same opcode, new operands, accepts three cycles apart.
        host_write(2'd0, 4'hF);
        host_write(2'd1, 4'h3);
        host_write(2'd2, 4'hC);
        host_write(2'd3, 4'hA);
        issue(4'b0000, 2'd0, 2'd0, 2'd1, 0, 2'd0, 4'd0);
        check("and1_const", result_data, 4'h3);
        prev_accept = accept_cyc;
        issue(4'b0000, 2'd1, 2'd2, 2'd3, 0, 2'd0, 4'd0);
        check("and2_const", result_data, 4'h8);
        check("and_accept_spacing", accept_cyc - prev_accept, 3);

        // 3 - 5 wraps; carry flag is untouched. Then 7 / 0.
        host_write(2'd0, 4'd3);
        host_write(2'd1, 4'd5);
        issue(4'b0100, 2'd2, 2'd0, 2'd1, 0, 2'd0, 4'd0);
        check("sub_const", result_data, 4'hE);
        check("sub_carry_kept", result_carry, 1);
        host_write(2'd3, 4'd7);
        host_write(2'd0, 4'd0);
        issue(4'b1010, 2'd1, 2'd3, 2'd0, 0, 2'd0, 4'd0);
        check("div0_data_const", result_data, 4'h0);
        check("div0_err_const", result_err, 1);

        // Host write colliding with writeback, then to a different address, then at accept.
        issue(4'b0001, 2'd2, 2'd3, 2'd3, 2, 2'd2, 4'd5);
        check("collide_wb_wins", dut.rf[2], 4'd7);
        issue(4'b0001, 2'd2, 2'd3, 2'd1, 2, 2'd0, 4'd6);
        check("nocollide_host", dut.rf[0], 4'd6);
        issue(4'b0111, 2'd1, 2'd3, 2'd3, 1, 2'd3, 4'd2);

        // Randomized traffic including dependent and idle-gapped instructions.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                host_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) tick();
            issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        // Reset while EXEC of an OR into r3: no writeback, no pulse.
        tick();
        instr_valid  = 1'b1;
        instr_opcode = 4'b0001;
        instr_rd     = 2'd3;
        instr_ra     = 2'd0;
        instr_rb     = 2'd1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("pre_abort_exec", alu_opcode, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", result_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", instr_ready, 1);
        check("abort_opcode", alu_opcode, 4'hF);
        check("abort_rf3", dut.rf[3], 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_pulse", result_valid, 0);
            check("abort_idle", busy, 0);
        end
        check("abort_rf3_after", dut.rf[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
